// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, jalr gating, MEM-stage forwarding and a
// timed memory-phase FSM. Optional forwarding is enabled with macro HAZARD_FWD_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int NUM_SRC     = 2
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic [REG_W-1:0]                     rs1ID,
  input  logic [REG_W-1:0]                     rs2ID,
  input  logic [REG_W-1:0]                     rs3ID,
  input  logic [REG_W-1:0]                     rdEx,
  input  logic [REG_W-1:0]                     rdMem,
  input  logic                                 regWriteEX,
  input  logic                                 regWriteMEM,
  input  logic                                 memReadEX,
  input  logic                                 memWriteEX,
  input  logic                                 branchCU,
  input  logic                                 jumpRegCU,
  input  logic                                 mem_ready,
  output logic                                 IF_ID_write,
  output logic                                 PC_write,
  output logic                                 ID_Ex_enable,
  output logic                                 pcStall,
  output logic                                 branchHU,
  output logic                                 jumpRegHU,
  output logic                                 fwdA,
  output logic                                 fwdB,
  output logic                                 mem_busy,
  output logic                                 mem_timeout,
  output logic [1:0]                           o_dbg_state,
  output logic [$clog2(MEM_TIMEOUT+1)-1:0]     o_dbg_cnt
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT+1);
  localparam logic SRC2_EN = (NUM_SRC >= 2);
  localparam logic SRC3_EN = (NUM_SRC >= 3);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARM       = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_timeout, w_timeout_nxt, w_hit;

  function automatic logic f_match(input logic wr, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] r);
    return wr && (rd != '0) && (rd == r);
  endfunction

  logic w_ex1, w_ex2, w_ex3, w_mem1, w_mem2, w_mem3;
  logic w_ex_stall, w_jr_stall, w_mem_stall, w_fwd_stall, w_stall;

  assign w_ex1  = f_match(regWriteEX, rdEx, rs1ID);
  assign w_ex2  = SRC2_EN & f_match(regWriteEX, rdEx, rs2ID);
  assign w_ex3  = SRC3_EN & f_match(regWriteEX, rdEx, rs3ID);
  assign w_mem1 = f_match(regWriteMEM, rdMem, rs1ID);
  assign w_mem2 = SRC2_EN & f_match(regWriteMEM, rdMem, rs2ID);
  assign w_mem3 = SRC3_EN & f_match(regWriteMEM, rdMem, rs3ID);

  assign w_ex_stall  = w_ex1 | w_ex2 | w_ex3;
  assign w_jr_stall  = jumpRegCU & w_ex1;
  assign w_mem_stall = mem_busy | memReadEX | memWriteEX;

`ifdef HAZARD_FWD_EN
  // rs1/rs2 take the MEM result through the bypass; rs3 has no bypass path.
  assign fwdA        = w_mem1 & ~w_ex1;
  assign fwdB        = w_mem2 & ~w_ex2;
  assign w_fwd_stall = w_mem3;
`else
  assign fwdA        = 1'b0;
  assign fwdB        = 1'b0;
  assign w_fwd_stall = w_mem1 | w_mem2 | w_mem3;
`endif

  assign w_stall      = w_ex_stall | w_jr_stall | w_mem_stall | w_fwd_stall;
  assign IF_ID_write  = ~w_stall;
  assign PC_write     = ~w_stall;
  assign ID_Ex_enable = ~w_stall;
  assign pcStall      = w_stall;
  assign branchHU     = branchCU & ~w_stall;
  assign jumpRegHU    = jumpRegCU & ~w_stall;

  assign mem_busy    = (r_state != S_IDLE);
  assign mem_timeout = r_timeout;
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

  // mem_ready low means busy: ARM waits for the memory to go busy, WAIT_DONE for it to finish.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_nxt = 1'b0;
    w_cnt_inc     = (r_cnt == CNT_W'(MEM_TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);
    w_hit         = (w_cnt_inc == CNT_W'(MEM_TIMEOUT));
    case (r_state)
      S_IDLE: begin
        if (memReadEX || memWriteEX) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (w_hit) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else if (!mem_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_hit) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else if (mem_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt != r_state)  w_cnt_nxt = '0;
    else if (r_state != S_IDLE)  w_cnt_nxt = w_cnt_inc;
    else                         w_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: combinational vector table, directed memory-phase
// sequences and randomized cycles checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5;
  localparam int TO = 4;
  localparam int NS = 3;
`ifdef HAZARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN;
  logic [RW-1:0] rs1ID, rs2ID, rs3ID, rdEx, rdMem;
  logic regWriteEX, regWriteMEM, memReadEX, memWriteEX, branchCU, jumpRegCU, mem_ready;

  logic IF_ID_write, PC_write, ID_Ex_enable, pcStall, branchHU, jumpRegHU;
  logic fwdA, fwdB, mem_busy, mem_timeout;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cnt;

  logic IF_ID_write_2, PC_write_2, ID_Ex_enable_2, pcStall_2, branchHU_2, jumpRegHU_2;
  logic fwdA_2, fwdB_2, mem_busy_2, mem_timeout_2;
  logic [1:0] dbg_state_2;
  logic [7:0] dbg_cnt_2;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(RW), .MEM_TIMEOUT(TO), .NUM_SRC(NS)) dut (
    .clk(clk), .rstN(rstN), .rs1ID(rs1ID), .rs2ID(rs2ID), .rs3ID(rs3ID),
    .rdEx(rdEx), .rdMem(rdMem), .regWriteEX(regWriteEX), .regWriteMEM(regWriteMEM),
    .memReadEX(memReadEX), .memWriteEX(memWriteEX), .branchCU(branchCU),
    .jumpRegCU(jumpRegCU), .mem_ready(mem_ready), .IF_ID_write(IF_ID_write),
    .PC_write(PC_write), .ID_Ex_enable(ID_Ex_enable), .pcStall(pcStall),
    .branchHU(branchHU), .jumpRegHU(jumpRegHU), .fwdA(fwdA), .fwdB(fwdB),
    .mem_busy(mem_busy), .mem_timeout(mem_timeout), .o_dbg_state(dbg_state),
    .o_dbg_cnt(dbg_cnt));

  pipeline_hazard_ctrl dut2 (
    .clk(clk), .rstN(rstN), .rs1ID(rs1ID), .rs2ID(rs2ID), .rs3ID(rs3ID),
    .rdEx(rdEx), .rdMem(rdMem), .regWriteEX(regWriteEX), .regWriteMEM(regWriteMEM),
    .memReadEX(memReadEX), .memWriteEX(memWriteEX), .branchCU(branchCU),
    .jumpRegCU(jumpRegCU), .mem_ready(mem_ready), .IF_ID_write(IF_ID_write_2),
    .PC_write(PC_write_2), .ID_Ex_enable(ID_Ex_enable_2), .pcStall(pcStall_2),
    .branchHU(branchHU_2), .jumpRegHU(jumpRegHU_2), .fwdA(fwdA_2), .fwdB(fwdB_2),
    .mem_busy(mem_busy_2), .mem_timeout(mem_timeout_2), .o_dbg_state(dbg_state_2),
    .o_dbg_cnt(dbg_cnt_2));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {rs1ID, rs2ID, rs3ID, rdEx, rdMem} = '0;
    {regWriteEX, regWriteMEM, memReadEX, memWriteEX, branchCU, jumpRegCU} = '0;
    mem_ready = 1'b1;
  endtask

  // Behavioural model: phase 0 = idle, 1 = armed, 2 = waiting for completion.
  int m_phase, m_cnt;
  bit m_to;

  function automatic bit m_match(input bit wr, input int rd, input int r);
    return wr && (rd != 0) && (rd == r);
  endfunction

  function automatic logic [14:0] m_expect();
    int  srcs[3];
    bit  ex_any, mem_any, fa, fb, fstall, stall;
    srcs[0] = rs1ID; srcs[1] = rs2ID; srcs[2] = rs3ID;
    ex_any = 0; mem_any = 0;
    for (int i = 0; i < NS; i++) begin
      ex_any  |= m_match(regWriteEX, rdEx, srcs[i]);
      mem_any |= m_match(regWriteMEM, rdMem, srcs[i]);
    end
    if (FWD) begin
      fa     = m_match(regWriteMEM, rdMem, rs1ID) && !m_match(regWriteEX, rdEx, rs1ID);
      fb     = m_match(regWriteMEM, rdMem, rs2ID) && !m_match(regWriteEX, rdEx, rs2ID);
      fstall = (NS >= 3) && m_match(regWriteMEM, rdMem, rs3ID);
    end else begin
      fa = 0; fb = 0; fstall = mem_any;
    end
    stall = ex_any || (jumpRegCU && m_match(regWriteEX, rdEx, rs1ID)) ||
            (m_phase != 0) || memReadEX || memWriteEX || fstall;
    return {~stall, ~stall, ~stall, stall, branchCU & ~stall, jumpRegCU & ~stall,
            fa, fb, (m_phase != 0), m_to, 2'(m_phase), 3'(m_cnt)};
  endfunction

  task automatic m_advance();
    if (!rstN) begin
      m_phase = 0; m_cnt = 0; m_to = 0;
    end else if (m_phase == 0) begin
      m_to = 0;
      if (memReadEX || memWriteEX) m_phase = 1;
      m_cnt = 0;
    end else begin
      m_to = 0;
      if (m_cnt + 1 >= TO) begin
        m_phase = 0; m_cnt = 0; m_to = 1;
      end else if (m_phase == 1 && !mem_ready) begin
        m_phase = 2; m_cnt = 0;
      end else if (m_phase == 2 && mem_ready) begin
        m_phase = 0; m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  typedef struct {
    logic rwex, rwmem, br, jr;
    logic [RW-1:0] rdex, rdmem, r1, r2, r3;
    logic e_stall, e_br, e_jr, e_fa, e_fb, e_stall2;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b1, 5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0, 5'd5,5'd0,5'd0,5'd5,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b0, 5'd0,5'd0,5'd0,5'd5,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0, 5'd5,5'd0,5'd5,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1, 5'd3,5'd0,5'd3,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1, 5'd3,5'd0,5'd4,5'd0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0, 5'd0,5'd7,5'd7,5'd0,5'd0, ~FWD,FWD,1'b0,FWD,1'b0,~FWD};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0, 5'd0,5'd7,5'd0,5'd7,5'd0, ~FWD,1'b0,1'b0,1'b0,FWD,~FWD};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0, 5'd0,5'd7,5'd0,5'd0,5'd7, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 5'd7,5'd7,5'd7,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0, 5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b0, 5'd9,5'd0,5'd0,5'd0,5'd9, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};

    idle_inputs();
    rstN = 1'b0;
    tick(); tick();
    rstN = 1'b1;
    @(negedge clk);
    chk("reset_if_id_write", IF_ID_write, 1'b1);
    chk("reset_pc_write", PC_write, 1'b1);
    chk("reset_id_ex_enable", ID_Ex_enable, 1'b1);
    chk("reset_pcstall", pcStall, 1'b0);
    chk("reset_fwd", {fwdA, fwdB}, 2'b00);
    chk("reset_mem_busy", mem_busy, 1'b0);
    chk("reset_mem_timeout", mem_timeout, 1'b0);
    chk("reset_state", dbg_state, 2'd0);
    chk("reset_cnt", dbg_cnt, 3'd0);

    for (int i = 0; i < 12; i++) begin
      regWriteEX = tbl[i].rwex; regWriteMEM = tbl[i].rwmem;
      branchCU = tbl[i].br; jumpRegCU = tbl[i].jr;
      rdEx = tbl[i].rdex; rdMem = tbl[i].rdmem;
      rs1ID = tbl[i].r1; rs2ID = tbl[i].r2; rs3ID = tbl[i].r3;
      #1;
      chk($sformatf("vec%0d_stall", i), pcStall, tbl[i].e_stall);
      chk($sformatf("vec%0d_enables", i), {IF_ID_write, PC_write, ID_Ex_enable},
          {3{~tbl[i].e_stall}});
      chk($sformatf("vec%0d_branchHU", i), branchHU, tbl[i].e_br);
      chk($sformatf("vec%0d_jumpRegHU", i), jumpRegHU, tbl[i].e_jr);
      chk($sformatf("vec%0d_fwd", i), {fwdA, fwdB}, {tbl[i].e_fa, tbl[i].e_fb});
      chk($sformatf("vec%0d_stall_nsrc2", i), pcStall_2, tbl[i].e_stall2);
    end

    idle_inputs();
    tick();
    memReadEX = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("load_c0_stall", pcStall, 1'b1);
    chk("load_c0_state", dbg_state, 2'd0);
    tick();
    memReadEX = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("load_c1_stall", pcStall, 1'b1);
    chk("load_c1_state", dbg_state, 2'd1);
    tick();
    @(negedge clk);
    chk("load_c2_stall", pcStall, 1'b1);
    chk("load_c2_state", dbg_state, 2'd2);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("load_c3_stall", pcStall, 1'b1);
    chk("load_c3_state", dbg_state, 2'd2);
    tick();
    @(negedge clk);
    chk("load_c4_stall", pcStall, 1'b0);
    chk("load_c4_state", dbg_state, 2'd0);
    chk("load_c4_enables", {IF_ID_write, PC_write, ID_Ex_enable}, 3'b111);
    chk("load_c4_timeout", mem_timeout, 1'b0);

    tick();
    memWriteEX = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("to_c0_state", dbg_state, 2'd0);
    tick();
    memWriteEX = 1'b0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk($sformatf("to_arm%0d_state", c), dbg_state, 2'd1);
      chk($sformatf("to_arm%0d_cnt", c), dbg_cnt, 3'(c));
      chk($sformatf("to_arm%0d_pulse", c), mem_timeout, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("to_exit_state", dbg_state, 2'd0);
    chk("to_exit_pulse", mem_timeout, 1'b1);
    chk("to_exit_stall", pcStall, 1'b0);
    tick();
    @(negedge clk);
    chk("to_after_pulse", mem_timeout, 1'b0);

    tick();
    memReadEX = 1'b1;
    tick();
    memReadEX = 1'b0; mem_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_pre_state", dbg_state, 2'd2);
    tick();
    rstN = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_wait_busy", mem_busy, 1'b0);
    chk("rst_wait_cnt", dbg_cnt, 3'd0);
    chk("rst_wait_enables", {IF_ID_write, PC_write, ID_Ex_enable}, 3'b111);
    chk("rst_wait_timeout", mem_timeout, 1'b0);
    rstN = 1'b1;
    idle_inputs();
    tick();

    m_phase = 0; m_cnt = 0; m_to = 0;
    for (int k = 0; k < 3000; k++) begin
      rs1ID = RW'($urandom_range(0, 3)); rs2ID = RW'($urandom_range(0, 3));
      rs3ID = RW'($urandom_range(0, 3)); rdEx = RW'($urandom_range(0, 3));
      rdMem = RW'($urandom_range(0, 3));
      regWriteEX = 1'($urandom_range(0, 1)); regWriteMEM = 1'($urandom_range(0, 1));
      memReadEX = ($urandom_range(0, 7) == 0); memWriteEX = ($urandom_range(0, 7) == 0);
      branchCU = 1'($urandom_range(0, 1)); jumpRegCU = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 2) != 0);
      rstN = ($urandom_range(0, 63) != 0);
      @(negedge clk);
      chk($sformatf("rand%0d", k),
          {IF_ID_write, PC_write, ID_Ex_enable, pcStall, branchHU, jumpRegHU,
           fwdA, fwdB, mem_busy, mem_timeout, dbg_state, dbg_cnt}, m_expect());
      m_advance();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
